ub_port_schedule_ctrl: RTL and testbench

- Issue controller for one unified-buffer access port (a write port or read port of a `*_ub` module).
- Walks a 4-deep rectangular iteration domain and drives the port's enable plus its `ctrl_vars[3:0]` bus.
- `ctrl_vars[3]` is innermost (stride-1 address dimension); `ctrl_vars[0]` is outermost.
- Issue cadence is fixed by a start delay and an initiation interval. A `flush` pulse (re)starts the schedule, so a producer port and a consumer port can be aligned by delay alone.

---
 rtl/ub_port_schedule_ctrl.sv | 119 +++++++++++
 tb/tb_ub_port_schedule_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_port_schedule_ctrl.sv
// Issue controller for one unified-buffer access port.
// Walks a 4-deep rectangular iteration domain (ctrl_vars[3] innermost) after a
// programmable start delay, issuing one point every II cycles while en is high.
module ub_port_schedule_ctrl #(
    parameter int unsigned W     = 16,
    parameter int unsigned EXT0  = 1,
    parameter int unsigned EXT1  = 4,
    parameter int unsigned EXT2  = 32,
    parameter int unsigned EXT3  = 32,
    parameter int unsigned DELAY = 0,
    parameter int unsigned II    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              en,
    output logic              port_en,
    output logic [3:0][W-1:0] ctrl_vars,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IiW          = (II > 1) ? $clog2(II) : 1;
    localparam int unsigned DelayLastInt = (DELAY > 0) ? DELAY - 1 : 0;
    localparam logic [15:0] DelayLast    = 16'(DelayLastInt);
    localparam logic [IiW-1:0] IiLast    = IiW'(II - 1);
    // Last value of each loop variable; index 3 is the innermost dimension.
    localparam logic [3:0][W-1:0] ExtLast = {W'(EXT3 - 1), W'(EXT2 - 1),
                                             W'(EXT1 - 1), W'(EXT0 - 1)};

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       delay_cnt_q, delay_cnt_d;
    logic [IiW-1:0]    ii_cnt_q, ii_cnt_d;
    logic [3:0][W-1:0] idx_q, idx_d;
    logic              issue;
    logic              carry;

    // Next-state, counter update and issue decode.
    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        ii_cnt_d    = ii_cnt_q;
        idx_d       = idx_q;
        carry       = 1'b0;
        issue       = (state_q == StRun) && (ii_cnt_q == '0) && en;

        if (flush) begin
            // Restart ignores en so producer/consumer ports stay aligned.
            state_d     = (DELAY > 0) ? StDelay : StRun;
            delay_cnt_d = '0;
            ii_cnt_d    = '0;
            idx_d       = '0;
        end else if (en) begin
            case (state_q)
                StDelay: begin
                    if (delay_cnt_q == DelayLast) begin
                        state_d     = StRun;
                        delay_cnt_d = '0;
                    end else begin
                        delay_cnt_d = delay_cnt_q + 16'd1;
                    end
                end
                StRun: begin
                    ii_cnt_d = (ii_cnt_q == IiLast) ? '0 : ii_cnt_q + IiW'(1);
                    if (issue) begin
                        // Ripple carry from the innermost variable outward.
                        carry = 1'b1;
                        for (int k = 3; k >= 0; k--) begin
                            if (carry) begin
                                if (idx_q[k] == ExtLast[k]) begin
                                    idx_d[k] = '0;
                                end else begin
                                    idx_d[k] = idx_q[k] + W'(1);
                                    carry    = 1'b0;
                                end
                            end
                        end
                        // Carry out of the outermost variable: sweep complete.
                        if (carry) begin
                            state_d = StDone;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            delay_cnt_q <= '0;
            ii_cnt_q    <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            delay_cnt_q <= delay_cnt_d;
            ii_cnt_q    <= ii_cnt_d;
            idx_q       <= idx_d;
        end
    end

    // Port-facing outputs.
    always_comb begin
        port_en   = issue;
        ctrl_vars = idx_q;
        busy      = (state_q == StDelay) || (state_q == StRun);
        done      = (state_q == StDone);
    end

endmodule

// File: tb/tb_ub_port_schedule_ctrl.sv
// Directed bench for ub_port_schedule_ctrl: default 1x4x32x32 sweep plus a
// small 1x1x2x3 config with DELAY=5, II=2 checked cycle by cycle from tables.
module tb_ub_port_schedule_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              flush_a, en_a, flush_b, en_b;
    logic              pe_a, busy_a, done_a;
    logic              pe_b, busy_b, done_b;
    logic [3:0][15:0]  cv_a, cv_b;

    ub_port_schedule_ctrl u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_a),
        .en        (en_a),
        .port_en   (pe_a),
        .ctrl_vars (cv_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    ub_port_schedule_ctrl #(
        .W     (16),
        .EXT0  (1),
        .EXT1  (1),
        .EXT2  (2),
        .EXT3  (3),
        .DELAY (5),
        .II    (2)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_b),
        .en        (en_b),
        .port_en   (pe_b),
        .ctrl_vars (cv_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    typedef struct {
        logic        en;
        logic        pe;
        logic [15:0] i2;
        logic [15:0] i3;
        logic        busy;
        logic        done;
    } vec_t;

    // Entry k describes cycle t+k+1 after the flush edge t.
    vec_t run_tbl[18];
    vec_t stall_tbl[21];

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(input int en, input int pe, input int i2, input int i3,
                                input int busy, input int done);
        vec_t v;
        v.en   = en[0];
        v.pe   = pe[0];
        v.i2   = 16'(i2);
        v.i3   = 16'(i3);
        v.busy = busy[0];
        v.done = done[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush_b();
        flush_b = 1'b1;
        step();
        flush_b = 1'b0;
    endtask

    // Apply one of the B tables starting just after a flush edge.
    task automatic run_b_table(input bit stall, input string tag);
        int   n;
        vec_t v;
        n = stall ? 21 : 18;
        for (int k = 0; k < n; k++) begin
            v    = stall ? stall_tbl[k] : run_tbl[k];
            en_b = v.en;
            @(negedge clk);
            chk($sformatf("%s_c%0d_port_en", tag, k + 1), 64'(pe_b), 64'(v.pe));
            chk($sformatf("%s_c%0d_ctrl_vars", tag, k + 1), cv_b, {v.i3, v.i2, 32'h0});
            chk($sformatf("%s_c%0d_busy", tag, k + 1), 64'(busy_b), 64'(v.busy));
            chk($sformatf("%s_c%0d_done", tag, k + 1), 64'(done_b), 64'(v.done));
            step();
        end
        en_b = 1'b1;
    endtask

    initial begin
        int issues;
        int bad;
        logic [63:0] exp_cv;

        // Uninterrupted sweep: issues on cycles 6,8,...,16, done from 17.
        for (int k = 0; k < 5; k++) run_tbl[k] = mk(1, 0, 0, 0, 1, 0);
        run_tbl[5]  = mk(1, 1, 0, 0, 1, 0);
        run_tbl[6]  = mk(1, 0, 0, 1, 1, 0);
        run_tbl[7]  = mk(1, 1, 0, 1, 1, 0);
        run_tbl[8]  = mk(1, 0, 0, 2, 1, 0);
        run_tbl[9]  = mk(1, 1, 0, 2, 1, 0);
        run_tbl[10] = mk(1, 0, 1, 0, 1, 0);
        run_tbl[11] = mk(1, 1, 1, 0, 1, 0);
        run_tbl[12] = mk(1, 0, 1, 1, 1, 0);
        run_tbl[13] = mk(1, 1, 1, 1, 1, 0);
        run_tbl[14] = mk(1, 0, 1, 2, 1, 0);
        run_tbl[15] = mk(1, 1, 1, 2, 1, 0);
        run_tbl[16] = mk(1, 0, 0, 0, 0, 1);
        run_tbl[17] = mk(1, 0, 0, 0, 0, 1);

        // en low on cycles 9..11 freezes ii_cnt mid-interval (ii_cnt=1), so the
        // following issue lands one cycle after en returns.
        for (int k = 0; k < 5; k++) stall_tbl[k] = mk(1, 0, 0, 0, 1, 0);
        stall_tbl[5]  = mk(1, 1, 0, 0, 1, 0);
        stall_tbl[6]  = mk(1, 0, 0, 1, 1, 0);
        stall_tbl[7]  = mk(1, 1, 0, 1, 1, 0);
        stall_tbl[8]  = mk(0, 0, 0, 2, 1, 0);
        stall_tbl[9]  = mk(0, 0, 0, 2, 1, 0);
        stall_tbl[10] = mk(0, 0, 0, 2, 1, 0);
        stall_tbl[11] = mk(1, 0, 0, 2, 1, 0);
        stall_tbl[12] = mk(1, 1, 0, 2, 1, 0);
        stall_tbl[13] = mk(1, 0, 1, 0, 1, 0);
        stall_tbl[14] = mk(1, 1, 1, 0, 1, 0);
        stall_tbl[15] = mk(1, 0, 1, 1, 1, 0);
        stall_tbl[16] = mk(1, 1, 1, 1, 1, 0);
        stall_tbl[17] = mk(1, 0, 1, 2, 1, 0);
        stall_tbl[18] = mk(1, 1, 1, 2, 1, 0);
        stall_tbl[19] = mk(1, 0, 0, 0, 0, 1);
        stall_tbl[20] = mk(1, 0, 0, 0, 0, 1);

        rst     = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        en_a    = 1'b1;
        en_b    = 1'b1;
        step();
        step();
        step();
        rst = 1'b0;

        // Reset state holds while no flush arrives.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("rst_a_port_en", 64'(pe_a), 64'h0);
            chk("rst_a_busy", 64'(busy_a), 64'h0);
            chk("rst_a_done", 64'(done_a), 64'h0);
            chk("rst_a_ctrl_vars", cv_a, 64'h0);
            chk("rst_b_port_en", 64'(pe_b), 64'h0);
            chk("rst_b_busy", 64'(busy_b), 64'h0);
            chk("rst_b_done", 64'(done_b), 64'h0);
            chk("rst_b_ctrl_vars", cv_b, 64'h0);
            step();
        end

        // Default config: 4096 back-to-back issues starting the cycle after flush.
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        issues = 0;
        bad    = 0;
        for (int k = 1; k <= 4096; k++) begin
            @(negedge clk);
            exp_cv = {16'((k - 1) % 32), 16'(((k - 1) / 32) % 32), 16'((k - 1) / 1024), 16'h0};
            if (pe_a === 1'b1) issues++;
            if (pe_a !== 1'b1 || cv_a !== exp_cv || done_a !== 1'b0 || busy_a !== 1'b1) bad++;
            if (k == 1) chk("a_first_issue_c1", 64'(pe_a), 64'h1);
            if (k == 4096) chk("a_last_point", cv_a, {16'd31, 16'd31, 16'd3, 16'd0});
            step();
        end
        chk("a_issue_count", 64'(issues), 64'd4096);
        chk("a_sweep_errors", 64'(bad), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("a_done_port_en", 64'(pe_a), 64'h0);
            chk("a_done_done", 64'(done_a), 64'h1);
            chk("a_done_busy", 64'(busy_a), 64'h0);
            chk("a_done_ctrl_vars", cv_a, 64'h0);
            step();
        end

        // Small config, uninterrupted and with a stall window.
        pulse_flush_b();
        run_b_table(1'b0, "b_run");
        pulse_flush_b();
        run_b_table(1'b1, "b_stall");

        // Flush on the third issue cycle abandons the sweep and restarts at (0,0).
        pulse_flush_b();
        for (int k = 0; k < 10; k++) begin
            if (k == 9) flush_b = 1'b1;
            @(negedge clk);
            chk($sformatf("b_abort_c%0d_port_en", k + 1), 64'(pe_b), 64'(run_tbl[k].pe));
            chk($sformatf("b_abort_c%0d_done", k + 1), 64'(done_b), 64'h0);
            step();
        end
        flush_b = 1'b0;
        run_b_table(1'b0, "b_restart");

        // rst together with flush mid-run wins; nothing issues until a new flush.
        pulse_flush_b();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                rst     = 1'b1;
                flush_b = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("b_prerst_c%0d_port_en", k + 1), 64'(pe_b), 64'(run_tbl[k].pe));
            step();
        end
        rst     = 1'b0;
        flush_b = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("b_postrst_port_en", 64'(pe_b), 64'h0);
            chk("b_postrst_busy", 64'(busy_b), 64'h0);
            chk("b_postrst_done", 64'(done_b), 64'h0);
            chk("b_postrst_ctrl_vars", cv_b, 64'h0);
            step();
        end
        pulse_flush_b();
        run_b_table(1'b0, "b_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
